// File: rtl/sipo_mc.sv
// sipo_mc: multi-lane serial-in/parallel-out deserializer with an output FIFO.
// Define SIPO_MC_PARITY_EN to append an even-parity bit per lane word and add m_perr.

module sipo_lane #(
  parameter int WIDTH = 8,
  parameter int IW    = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             shift,
  input  logic [IW-1:0]    pos,
  input  logic             sin,
  output logic [WIDTH-1:0] word
);
  logic [WIDTH-1:0] sr;

  // word already carries the bit being accepted, so a completing word can be pushed at this edge
  always_comb begin
    word = sr;
    if (shift) word[pos] = sin;
  end

  always_ff @(posedge clk) begin
    if (!rstn || clear) sr <= '0;
    else if (shift)     sr <= word;
  end
endmodule

module sipo_mc #(
  parameter int NCH   = 2,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NCH-1:0]           sin,
  input  logic                     sin_valid,
  input  logic                     en,
  input  logic                     msb_first,
  input  logic                     clear,
  input  logic                     flush,
  input  logic                     ovf_clr,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [NCH*WIDTH-1:0]     m_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt
`ifdef SIPO_MC_PARITY_EN
  ,
  output logic [NCH-1:0]           m_perr
`endif
);
`ifdef SIPO_MC_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int LAST = WIDTH - 1 + PAR;
  localparam int CW   = $clog2(LAST + 1);
  localparam int IW   = $clog2(WIDTH);
  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = AW + 1;

  logic [CW-1:0] cnt;
  logic          ord_q, eff_msb, acc, at_last, par_slot, shift, done;
  logic [IW-1:0] pos;
  logic [NCH-1:0][WIDTH-1:0] word;

  assign acc     = en & sin_valid;
  assign at_last = (cnt == CW'(LAST));
`ifdef SIPO_MC_PARITY_EN
  assign par_slot = at_last;
`else
  assign par_slot = 1'b0;
`endif
  // bit order is latched on the first bit so a mid-word msb_first change cannot scramble the word
  assign eff_msb = (cnt == '0) ? msb_first : ord_q;
  assign pos     = eff_msb ? (IW'(WIDTH - 1) - IW'(cnt)) : IW'(cnt);
  assign shift   = acc & ~clear & ~par_slot;
  assign done    = acc & at_last & ~clear;

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      cnt   <= '0;
      ord_q <= 1'b0;
    end else if (acc) begin
      cnt <= at_last ? '0 : cnt + CW'(1);
      if (cnt == '0) ord_q <= msb_first;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    sipo_lane #(.WIDTH(WIDTH), .IW(IW)) u_lane (
      .clk   (clk),
      .rstn  (rstn),
      .clear (clear),
      .shift (shift),
      .pos   (pos),
      .sin   (sin[k]),
      .word  (word[k])
    );
  end

  logic [PW-1:0] wptr, rptr;
  logic [AW-1:0] widx, ridx;
  logic          full, pop, push, drop;
  logic [NCH-1:0][WIDTH-1:0] mem_d [DEPTH];

  assign widx    = wptr[AW-1:0];
  assign ridx    = rptr[AW-1:0];
  assign full    = (widx == ridx) && (wptr[AW] != rptr[AW]);
  assign m_valid = (wptr != rptr);
  assign level   = wptr - rptr;
  assign pop     = m_valid & m_ready;
  // when full, a same-cycle pop frees the head slot that widx aliases
  assign push    = done & (~full | pop);
  assign drop    = done & full & ~pop & ~flush;
  assign m_data  = m_valid ? mem_d[ridx] : '0;

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_d[widx] <= word;
  end

`ifdef SIPO_MC_PARITY_EN
  logic [NCH-1:0] mem_p [DEPTH];

  always_ff @(posedge clk) begin
    if (push && !flush) mem_p[widx] <= sin;
  end

  always_comb begin
    m_perr = '0;
    if (m_valid)
      for (int k = 0; k < NCH; k++) m_perr[k] = (^mem_d[ridx][k]) ^ mem_p[ridx][k];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_sipo_mc.sv
// Directed bench for sipo_mc with a word-level queue model checked every cycle.
module tb_sipo_mc;
  localparam int NCH = 2, WIDTH = 8, DEPTH = 4, CNT_W = 2;
`ifdef SIPO_MC_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = WIDTH + PAR;

  logic clk = 1'b0;
  logic rstn, en, sin_valid, msb_first, clear, flush, ovf_clr, m_ready;
  logic [1:0]  sin;
  logic        m_valid, overflow;
  logic [15:0] m_data;
  logic [2:0]  level;
  logic [1:0]  drop_cnt;
`ifdef SIPO_MC_PARITY_EN
  logic [1:0]  m_perr;
`endif

  always #5 clk = ~clk;

  sipo_mc #(.NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .sin(sin), .sin_valid(sin_valid), .en(en),
    .msb_first(msb_first), .clear(clear), .flush(flush), .ovf_clr(ovf_clr),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .level(level),
    .overflow(overflow), .drop_cnt(drop_cnt)
`ifdef SIPO_MC_PARITY_EN
    , .m_perr(m_perr)
`endif
  );

  int checks = 0, errors = 0;
  bit cmp_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: received bits per word, then a queue of {perr, data} words
  logic [NCH-1:0] rx [WIDTH+1];
  int             nbits = 0;
  logic           ord;
  logic [17:0]    q[$];
  logic           mdl_ovf;
  int             mdl_dc;
  logic [15:0]    mw;
  logic [1:0]     mpe;
  bit             mdone, mpop, mdrop;

  always @(posedge clk) begin
    mdone = 0; mdrop = 0;
    if (!rstn) begin
      nbits = 0; q.delete(); mdl_ovf = 0; mdl_dc = 0;
    end else begin
      mpop = (q.size() != 0) && m_ready;
      if (clear) nbits = 0;
      else if (en && sin_valid) begin
        if (nbits == 0) ord = msb_first;
        rx[nbits] = sin;
        nbits++;
        if (nbits == NB) begin mdone = 1; nbits = 0; end
      end
      if (mdone) begin
        mw = '0; mpe = '0;
        for (int k = 0; k < NCH; k++) begin
          for (int i = 0; i < WIDTH; i++) begin
            mw[k*WIDTH + (ord ? WIDTH-1-i : i)] = rx[i][k];
            mpe[k] ^= rx[i][k];
          end
          if (PAR != 0) mpe[k] ^= rx[WIDTH][k];
          else          mpe[k] = 1'b0;
        end
      end
      if (flush) q.delete();
      else begin
        if (mpop) void'(q.pop_front());
        if (mdone) begin
          if (q.size() < DEPTH) q.push_back({mpe, mw});
          else mdrop = 1;
        end
      end
      if (mdrop) begin
        mdl_ovf = 1;
        if (mdl_dc < (1 << CNT_W) - 1) mdl_dc++;
      end else if (ovf_clr) mdl_ovf = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_valid", m_valid, q.size() != 0);
      chk("level", level, q.size());
      chk("overflow", overflow, mdl_ovf);
      chk("drop_cnt", drop_cnt, mdl_dc);
      if (q.size() != 0) begin
        chk("m_data", m_data, q[0][15:0]);
`ifdef SIPO_MC_PARITY_EN
        chk("m_perr", m_perr, q[0][17:16]);
`endif
      end
    end
  end

  // serial bits lo..hi of a word; first bit of s is s[7]; msb_first toggles after bit 0
  task automatic send_ser(input logic [7:0] s0, input logic [7:0] s1, input logic msb,
                          input int lo, input int hi, input logic rdy_last,
                          input logic ovc_last, input logic [1:0] pflip);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      en = 1; sin_valid = 1;
      msb_first = (i == 0) ? msb : ~msb;
      if (i < WIDTH) sin = {s1[7-i], s0[7-i]};
      else           sin = {^s1, ^s0} ^ pflip;
      m_ready = (i == NB-1) ? rdy_last : 1'b0;
      ovf_clr = (i == NB-1) ? ovc_last : 1'b0;
    end
    @(negedge clk);
    en = 0; sin_valid = 0; m_ready = 0; ovf_clr = 0;
  endtask

  task automatic word(input logic [7:0] s0, input logic [7:0] s1);
    send_ser(s0, s1, 1'b1, 0, NB-1, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic drain_expect(input logic [15:0] exp);
    @(negedge clk);
    chk("drain_valid", m_valid, 1);
    chk("drain_data", m_data, exp);
    m_ready = 1;
    @(negedge clk);
    m_ready = 0;
  endtask

  initial begin
    rstn = 0; en = 0; sin_valid = 0; msb_first = 1; clear = 0; flush = 0;
    ovf_clr = 0; m_ready = 0; sin = 0;
    repeat (2) @(negedge clk);
    rstn = 1; cmp_on = 1;
    chk("rst_valid", m_valid, 0); chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);  chk("rst_drop", drop_cnt, 0);
    chk("rst_data", m_data, 0);

    // bit order
    word(8'hB2, 8'hFF);
    chk("msb_data", m_data, 16'hFFB2); chk("msb_level", level, 1);
    drain_expect(16'hFFB2);
    send_ser(8'hB2, 8'hFF, 1'b0, 0, NB-1, 1'b0, 1'b0, 2'b00);
    chk("lsb_data", m_data, 16'hFF4D);
    drain_expect(16'hFF4D);

    // stall with en=0 while sin_valid toggles
    send_ser(8'hB2, 8'h00, 1'b1, 0, 2, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); en = 0; sin_valid = 1; sin = 2'($urandom);
    end
    @(negedge clk); sin_valid = 0;
    send_ser(8'hB2, 8'h00, 1'b1, 3, NB-2, 1'b0, 1'b0, 2'b00);
    chk("stall_level_pre", level, 0);
    send_ser(8'hB2, 8'h00, 1'b1, NB-1, NB-1, 1'b0, 1'b0, 2'b00);
    chk("stall_level", level, 1); chk("stall_data", m_data, 16'h00B2);
    drain_expect(16'h00B2);

    // overflow
    for (int i = 1; i <= 5; i++) word(8'(i), 8'(8'hA0 + i));
    chk("ovf_level", level, 4); chk("ovf_flag", overflow, 1); chk("ovf_cnt", drop_cnt, 1);
    for (int i = 1; i <= 4; i++) drain_expect({8'(8'hA0 + i), 8'(i)});
    @(negedge clk); ovf_clr = 1;
    @(negedge clk); ovf_clr = 0;
    chk("ovf_clr_flag", overflow, 0); chk("ovf_clr_cnt", drop_cnt, 1);

    // full with same-cycle pop
    for (int i = 1; i <= 4; i++) word(8'(i), 8'(8'hA0 + i));
    send_ser(8'h05, 8'hA5, 1'b1, 0, NB-1, 1'b1, 1'b0, 2'b00);
    chk("fpop_level", level, 4); chk("fpop_ovf", overflow, 0); chk("fpop_cnt", drop_cnt, 1);
    for (int i = 2; i <= 5; i++) drain_expect({8'(8'hA0 + i), 8'(i)});

    // saturation, drop beats ovf_clr
    for (int i = 0; i < 4; i++) word(8'(8'h10 + i), 8'h20);
    word(8'h77, 8'h77); word(8'h78, 8'h78);
    send_ser(8'h79, 8'h79, 1'b1, 0, NB-1, 1'b0, 1'b1, 2'b00);
    chk("sat_cnt", drop_cnt, 3); chk("sat_ovf", overflow, 1);

    // flush with level 3; partial word survives
    drain_expect(16'h2010);
    chk("flush_pre_level", level, 3);
    send_ser(8'hC3, 8'h3C, 1'b1, 0, 3, 1'b0, 1'b0, 2'b00);
    @(negedge clk); flush = 1; m_ready = 1;
    @(negedge clk); flush = 0; m_ready = 0;
    chk("flush_level", level, 0); chk("flush_valid", m_valid, 0);
    send_ser(8'hC3, 8'h3C, 1'b1, 4, NB-1, 1'b0, 1'b0, 2'b00);
    chk("flush_keep", m_data, 16'h3CC3);
    drain_expect(16'h3CC3);

    // clear mid-word, offered bit discarded
    send_ser(8'hFF, 8'hFF, 1'b1, 0, 4, 1'b0, 1'b0, 2'b00);
    @(negedge clk); clear = 1; en = 1; sin_valid = 1; sin = 2'b11;
    @(negedge clk); clear = 0; en = 0; sin_valid = 0;
    word(8'h3C, 8'h5A);
    chk("clr_level", level, 1); chk("clr_data", m_data, 16'h5A3C);
    drain_expect(16'h5A3C);

    // reset mid-word with level 2
    word(8'h11, 8'h22); word(8'h33, 8'h44);
    chk("rst2_pre", level, 2);
    send_ser(8'hFF, 8'hFF, 1'b1, 0, 2, 1'b0, 1'b0, 2'b00);
    @(negedge clk); rstn = 0;
    @(negedge clk); rstn = 1;
    chk("rst2_valid", m_valid, 0); chk("rst2_level", level, 0);
    chk("rst2_ovf", overflow, 0);  chk("rst2_cnt", drop_cnt, 0);
    chk("rst2_data", m_data, 0);
    word(8'h81, 8'h42);
    chk("rst2_fresh", m_data, 16'h4281);
    drain_expect(16'h4281);

`ifdef SIPO_MC_PARITY_EN
    send_ser(8'hB2, 8'hFF, 1'b1, 0, NB-1, 1'b0, 1'b0, 2'b10);
    chk("par_perr", m_perr, 2'b10); chk("par_data", m_data, 16'hFFB2);
    drain_expect(16'hFFB2);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
